// File: rtl/systolic_controller.sv
// Sequencing controller for the buffered systolic module: streams operand vectors
// into the double buffers, pulses swap/shift per step, then reads results out.
module systolic_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ADDR_WIDTH     = $clog2(MATRIX_SIZE),
  parameter int ACC_WIDTH      = 32,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter int STEP_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [STEP_WIDTH-1:0]     cfg_steps,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_top,
  input  logic [DATA_WIDTH-1:0]     in_left,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [ACC_ADDR_WIDTH-1:0] out_index,
  input  logic [ACC_WIDTH-1:0]      acc_in,
  output logic                      acc_rst,
  output logic                      acc_en,
  output logic                      shift_en_right,
  output logic                      shift_en_down,
  output logic                      buffer_rst_top,
  output logic                      buffer_rst_left,
  output logic                      load_en_top,
  output logic                      load_en_left,
  output logic                      swap_buffers_top,
  output logic                      swap_buffers_left,
  output logic [ADDR_WIDTH-1:0]     addr_top,
  output logic [ADDR_WIDTH-1:0]     addr_left,
  output logic [DATA_WIDTH-1:0]     data_in_top,
  output logic [DATA_WIDTH-1:0]     data_in_left,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SWAP, SHIFT, RADDR, ROUT} state_t;

  localparam logic [ADDR_WIDTH-1:0]     LAST_ELEM = ADDR_WIDTH'(MATRIX_SIZE - 1);
  localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX  = ACC_ADDR_WIDTH'(MATRIX_SIZE * MATRIX_SIZE - 1);

  state_t                state, next_state;
  logic [STEP_WIDTH-1:0] steps_q;
  logic [STEP_WIDTH-1:0] step_cnt;
  logic [STEP_WIDTH-1:0] step_inc;
  logic [ADDR_WIDTH-1:0] elem_cnt;
  logic                  beat;
  logic                  out_fire;
  logic                  last_elem;
  logic                  last_idx;
  logic                  steps_left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    in_ready   = (state == LOAD);
    out_valid  = (state == ROUT);
    beat       = in_valid && (state == LOAD);
    out_fire   = out_ready && (state == ROUT);
    last_elem  = (elem_cnt == LAST_ELEM);
    last_idx   = (addr_acc == LAST_IDX);
    // Step counter never wraps: compare the incremented value against the latched count.
    step_inc   = step_cnt + STEP_WIDTH'(1);
    steps_left = (step_inc != steps_q);
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = (steps_q != '0) ? LOAD : RADDR;
      LOAD:    if (beat && last_elem) next_state = SWAP;
      SWAP:    next_state = SHIFT;
      SHIFT:   next_state = steps_left ? LOAD : RADDR;
      RADDR:   next_state = ROUT;
      ROUT:    if (out_fire) next_state = last_idx ? IDLE : RADDR;
      default: next_state = IDLE;
    endcase
  end

  // Module controls are registered: each pulse lands one cycle after its cause,
  // so the final load_en coincides with SWAP and swap_buffers follows a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps_q           <= '0;
      step_cnt          <= '0;
      elem_cnt          <= '0;
      done              <= 1'b0;
      out_data          <= '0;
      out_index         <= '0;
      acc_rst           <= 1'b0;
      acc_en            <= 1'b0;
      shift_en_right    <= 1'b0;
      shift_en_down     <= 1'b0;
      buffer_rst_top    <= 1'b0;
      buffer_rst_left   <= 1'b0;
      load_en_top       <= 1'b0;
      load_en_left      <= 1'b0;
      swap_buffers_top  <= 1'b0;
      swap_buffers_left <= 1'b0;
      addr_top          <= '0;
      addr_left         <= '0;
      data_in_top       <= '0;
      data_in_left      <= '0;
      addr_acc          <= '0;
    end else begin
      acc_rst           <= (state == CLEAR);
      buffer_rst_top    <= (state == CLEAR);
      buffer_rst_left   <= (state == CLEAR);
      load_en_top       <= beat;
      load_en_left      <= beat;
      swap_buffers_top  <= (state == SWAP);
      swap_buffers_left <= (state == SWAP);
      acc_en            <= (state == SHIFT);
      shift_en_right    <= (state == SHIFT);
      shift_en_down     <= (state == SHIFT);
      done              <= out_fire && last_idx;

      if (beat) begin
        addr_top     <= elem_cnt;
        addr_left    <= elem_cnt;
        data_in_top  <= in_top;
        data_in_left <= in_left;
        elem_cnt     <= last_elem ? '0 : elem_cnt + ADDR_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            steps_q  <= cfg_steps;
            step_cnt <= '0;
            elem_cnt <= '0;
            addr_acc <= '0;
          end
        end
        CLEAR: addr_acc <= '0;
        SHIFT: begin
          step_cnt <= step_inc;
          if (!steps_left) addr_acc <= '0;
        end
        RADDR: begin
          out_data  <= acc_in;
          out_index <= addr_acc;
        end
        ROUT: begin
          if (out_fire && !last_idx) addr_acc <= addr_acc + ACC_ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_controller.sv
// Scoreboard bench for systolic_controller at N=2: random operand/result traffic,
// a behavioural systolic-module model, and an arithmetic outer-product reference.
`timescale 1ns/1ps
module tb_systolic_controller;

  localparam int DW  = 8;
  localparam int N   = 2;
  localparam int AW  = $clog2(N);
  localparam int ACW = 32;
  localparam int AAW = $clog2(N * N);
  localparam int SW  = 8;
  localparam int NN  = N * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [SW-1:0]  cfg_steps;
  logic           busy, done;
  logic           in_valid, in_ready;
  logic [DW-1:0]  in_top, in_left;
  logic           out_valid, out_ready;
  logic [ACW-1:0] out_data;
  logic [AAW-1:0] out_index;
  logic [ACW-1:0] acc_in;
  logic           acc_rst, acc_en, shift_en_right, shift_en_down;
  logic           buffer_rst_top, buffer_rst_left;
  logic           load_en_top, load_en_left, swap_buffers_top, swap_buffers_left;
  logic [AW-1:0]  addr_top, addr_left;
  logic [DW-1:0]  data_in_top, data_in_left;
  logic [AAW-1:0] addr_acc;

  always #5 clk = ~clk;

  systolic_controller #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(N), .ADDR_WIDTH(AW), .ACC_WIDTH(ACW),
    .ACC_ADDR_WIDTH(AAW), .STEP_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_steps(cfg_steps), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_top(in_top), .in_left(in_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .acc_in(acc_in), .acc_rst(acc_rst), .acc_en(acc_en),
    .shift_en_right(shift_en_right), .shift_en_down(shift_en_down),
    .buffer_rst_top(buffer_rst_top), .buffer_rst_left(buffer_rst_left),
    .load_en_top(load_en_top), .load_en_left(load_en_left),
    .swap_buffers_top(swap_buffers_top), .swap_buffers_left(swap_buffers_left),
    .addr_top(addr_top), .addr_left(addr_left),
    .data_in_top(data_in_top), .data_in_left(data_in_left), .addr_acc(addr_acc)
  );

  typedef struct {
    logic [AAW-1:0] idx;
    logic [ACW-1:0] val;
  } res_t;

  int unsigned tests    = 0;
  int unsigned fails    = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  bit          bp_mode  = 1'b0;
  res_t        sb[$];
  logic [DW-1:0] g_top[$];
  logic [DW-1:0] g_left[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic bail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got no event, required one", name);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Systolic module model: double buffers plus an outer-product accumulator.
  // Controls are applied mid-cycle so a readback in the same cycle sees them.
  logic [DW-1:0]  top_bank [2][N];
  logic [DW-1:0]  left_bank[2][N];
  logic [ACW-1:0] acc_m[NN];
  int unsigned    act_t, act_l;

  assign acc_in = acc_m[addr_acc];

  initial begin
    act_t = 0;
    act_l = 0;
    for (int unsigned i = 0; i < NN; i++) acc_m[i] = 32'hA5A5_0000 + i;
    for (int unsigned b = 0; b < 2; b++)
      for (int unsigned e = 0; e < N; e++) begin
        top_bank[b][e]  = DW'($urandom);
        left_bank[b][e] = DW'($urandom);
      end
    forever begin
      @(negedge clk);
      if (buffer_rst_top)
        for (int unsigned b = 0; b < 2; b++)
          for (int unsigned e = 0; e < N; e++) top_bank[b][e] = '0;
      if (buffer_rst_left)
        for (int unsigned b = 0; b < 2; b++)
          for (int unsigned e = 0; e < N; e++) left_bank[b][e] = '0;
      if (load_en_top)  top_bank[1 - act_t][addr_top]   = data_in_top;
      if (load_en_left) left_bank[1 - act_l][addr_left] = data_in_left;
      if (swap_buffers_top)  act_t = 1 - act_t;
      if (swap_buffers_left) act_l = 1 - act_l;
      if (acc_rst)
        for (int unsigned i = 0; i < NN; i++) acc_m[i] = '0;
      if (acc_en)
        for (int unsigned r = 0; r < N; r++)
          for (int unsigned c = 0; c < N; c++)
            acc_m[r*N+c] = acc_m[r*N+c] + ACW'(top_bank[act_t][c]) * ACW'(left_bank[act_l][r]);
    end
  end

  // Monitor: protocol checks and scoreboard pops, sampled on the falling edge.
  initial begin
    logic           pv_beat, pv_stall;
    logic [DW-1:0]  pv_top, pv_left;
    logic [ACW-1:0] pv_data;
    logic [AAW-1:0] pv_idx;
    int unsigned    beats, pv_elem;
    res_t           e;
    pv_beat = 1'b0; pv_stall = 1'b0; beats = 0; pv_elem = 0;
    pv_top = '0; pv_left = '0; pv_data = '0; pv_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_beat = 1'b0; pv_stall = 1'b0; beats = 0;
        continue;
      end
      if (load_en_top || load_en_left || pv_beat) begin
        check("load_en_top_vs_beat", load_en_top, pv_beat);
        check("load_en_left_vs_beat", load_en_left, pv_beat);
        if (pv_beat) begin
          check("addr_top", addr_top, pv_elem);
          check("addr_left", addr_left, pv_elem);
          check("data_in_top", data_in_top, pv_top);
          check("data_in_left", data_in_left, pv_left);
        end
      end
      if (swap_buffers_top || swap_buffers_left) begin
        check("swap_pair", {swap_buffers_top, swap_buffers_left}, 2'b11);
        check("beats_before_swap", beats, N);
        beats = 0;
      end
      if (acc_en || shift_en_right || shift_en_down)
        check("shift_group", {acc_en, shift_en_right, shift_en_down}, 3'b111);
      if (pv_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, pv_data);
        check("stall_index", out_index, pv_idx);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_index", out_index, e.idx);
          check("out_data", out_data, e.val);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 1'b0);
        check("results_drained", sb.size(), 0);
      end
      pv_beat = in_valid && in_ready;
      pv_elem = beats;
      if (pv_beat) beats++;
      pv_top   = in_top;
      pv_left  = in_left;
      pv_stall = out_valid && !out_ready;
      pv_data  = out_data;
      pv_idx   = out_index;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic fill_random(input int unsigned steps);
    g_top.delete();
    g_left.delete();
    for (int unsigned i = 0; i < steps * N; i++) begin
      g_top.push_back(DW'($urandom));
      g_left.push_back(DW'($urandom));
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] t, input logic [DW-1:0] l, input bit gaps);
    int unsigned waitc;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_top   = t;
    in_left  = l;
    waitc    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 50) bail("beat_accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int unsigned steps, input bit gaps, input bit inject);
    logic [ACW-1:0] exp_acc[NN];
    int unsigned    clear_cyc, d0, budget;
    for (int unsigned i = 0; i < NN; i++) exp_acc[i] = '0;
    for (int unsigned s = 0; s < steps; s++)
      for (int unsigned r = 0; r < N; r++)
        for (int unsigned c = 0; c < N; c++)
          exp_acc[r*N+c] += ACW'(g_top[s*N+c]) * ACW'(g_left[s*N+r]);
    for (int unsigned i = 0; i < NN; i++) sb.push_back('{idx: AAW'(i), val: exp_acc[i]});
    check("idle_before_start", busy, 1'b0);
    d0        = done_cnt;
    cfg_steps = SW'(steps);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_steps = SW'($urandom);
    @(negedge clk);
    check("busy_in_clear", busy, 1'b1);
    clear_cyc = cyc;
    for (int unsigned b = 0; b < steps * N; b++) begin
      if (inject && b == 1) begin
        start     = 1'b1;
        cfg_steps = SW'(steps + 3);
      end
      send_beat(g_top[b], g_left[b], gaps);
      start = 1'b0;
    end
    in_valid = 1'b0;
    budget   = 0;
    while (done_cnt == d0 && budget < 5000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (done_cnt == d0) bail("done_wait");
    if (!gaps && !bp_mode)
      check("cmd_cycles", done_cyc - clear_cyc + 1, 1 + steps * (N + 2) + NN * 2 + 1);
    repeat (3) @(negedge clk);
    #1;
    check("done_single_pulse", done_cnt, d0 + 1);
  endtask

  task automatic reset_mid_load();
    fill_random(2);
    check("idle_before_rst_cmd", busy, 1'b0);
    cfg_steps = 8'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int unsigned b = 0; b < 3; b++) send_beat(g_top[b], g_left[b], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    check("rst_controls_zero",
          {busy, done, in_ready, out_valid, acc_rst, acc_en, shift_en_right, shift_en_down,
           buffer_rst_top, buffer_rst_left, load_en_top, load_en_left, swap_buffers_top,
           swap_buffers_left, addr_top, addr_left, data_in_top, data_in_left, addr_acc}, '0);
    check("rst_outputs_zero", {out_data, out_index}, '0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {busy, in_ready, out_valid, done}, 4'b0000);
  endtask

  initial begin
    int unsigned st;
    rst = 1'b1; start = 1'b0; cfg_steps = '0;
    in_valid = 1'b0; in_top = '0; in_left = '0;
    repeat (3) @(negedge clk);
    check("reset_controls",
          {busy, done, in_ready, out_valid, acc_rst, acc_en, shift_en_right, shift_en_down,
           buffer_rst_top, buffer_rst_left, load_en_top, load_en_left, swap_buffers_top,
           swap_buffers_left, addr_top, addr_left, data_in_top, data_in_left, addr_acc}, '0);
    check("reset_outputs", {out_data, out_index}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    g_top  = '{8'd1, 8'd3};
    g_left = '{8'd2, 8'd4};
    run_cmd(1, 1'b0, 1'b0);

    g_top.delete();
    g_left.delete();
    run_cmd(0, 1'b0, 1'b0);

    fill_random(3);
    run_cmd(3, 1'b0, 1'b0);

    bp_mode = 1'b1;
    repeat (4) begin
      st = $urandom_range(1, 6);
      fill_random(st);
      run_cmd(st, 1'b1, 1'b0);
    end
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);

    fill_random(2);
    run_cmd(2, 1'b0, 1'b1);

    reset_mid_load();
    fill_random(3);
    run_cmd(3, 1'b1, 1'b0);

    fill_random(255);
    run_cmd(255, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
